// File: rtl/gfx_pkg.sv
// Shared types for the gfx block family.
// Provides the 32-bit word type, AXI length/burst encodings, the fetch
// length type and the burst reader FSM state encoding.
package gfx;

    typedef logic [31:0] word;
    typedef logic [7:0]  axi_len;
    typedef logic [15:0] fetch_len;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CALC = 2'd1,
        RD_ADDR = 2'd2
    } rd_state_e;

endpackage

// File: rtl/gfx_axib.sv
// AXI4 burst bus (no IDs, no response codes) between a gfx master and slave.
// Modport m: master drives AW/W/AR valids and payloads plus bready/rready.
// Modport s: slave side, the mirror image.
interface gfx_axib;

    logic          awvalid;
    logic          awready;
    gfx::word      awaddr;
    gfx::axi_len   awlen;
    logic [1:0]    awburst;

    logic          wvalid;
    logic          wready;
    gfx::word      wdata;
    logic          wlast;

    logic          bvalid;
    logic          bready;

    logic          arvalid;
    logic          arready;
    gfx::word      araddr;
    gfx::axi_len   arlen;
    logic [1:0]    arburst;

    logic          rvalid;
    logic          rready;
    gfx::word      rdata;
    logic          rlast;

    modport m (
        output awvalid, awaddr, awlen, awburst, wvalid, wdata, wlast, bready,
               arvalid, araddr, arlen, arburst, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport s (
        input  awvalid, awaddr, awlen, awburst, wvalid, wdata, wlast, bready,
               arvalid, araddr, arlen, arburst, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

endinterface

// File: rtl/gfx_fifo.sv
// Synchronous FIFO, first-word-fall-through with a registered output stage.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   wr_en_i, wr_data_i      push (caller guarantees room)
//   rd_valid_o, rd_ready_i  head-of-queue handshake
//   rd_data_o               head word, driven from a flop
//   count_o                 total entries held, output stage included
module gfx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    mcnt_q, mcnt_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    logic pop, load, mem_empty, from_mem, bypass, to_mem;

    always_comb begin
        pop       = vld_q && rd_ready_i;
        load      = !vld_q || pop;
        mem_empty = (mcnt_q == '0);
        from_mem  = load && !mem_empty;
        // Empty queue: a push lands straight in the output stage.
        bypass    = load && mem_empty && wr_en_i;
        to_mem    = wr_en_i && !bypass;

        mcnt_d = mcnt_q;
        if (to_mem && !from_mem)      mcnt_d = mcnt_q + CW'(1);
        else if (!to_mem && from_mem) mcnt_d = mcnt_q - CW'(1);

        vld_d = vld_q;
        dat_d = dat_q;
        if (load) vld_d = !mem_empty || wr_en_i;
        if (from_mem)    dat_d = mem_q[rd_ptr_q];
        else if (bypass) dat_d = wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mcnt_q   <= '0;
            vld_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            if (to_mem)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (from_mem) rd_ptr_q <= rd_ptr_q + AW'(1);
            mcnt_q <= mcnt_d;
            vld_q  <= vld_d;
            dat_q  <= dat_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (to_mem) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_valid_o = vld_q;
    assign rd_data_o  = dat_q;
    assign count_o    = mcnt_q + CW'(vld_q);

endmodule

// File: rtl/gfx_burst_reader.sv
// Read-side AXI4 burst master. Splits a linear fetch (byte address, word
// count) into INCR bursts that stay inside 4 KiB pages and only issues a
// burst once the FIFO can absorb every beat, so rready never drops.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   mem                               AXI master (read channels only)
//   req_valid/req_ready/addr/len      fetch request
//   out_valid/out_ready/data/last     word stream, last marks request end
module gfx_burst_reader
    import gfx::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    gfx_axib.m         mem,
    input  logic       req_valid,
    output logic       req_ready,
    input  word        req_addr,
    input  fetch_len   req_len,
    output logic       out_valid,
    input  logic       out_ready,
    output word        out_data,
    output logic       out_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e      state_q, state_d;
    word            addr_q, addr_d;
    fetch_len       rem_q, rem_d;
    fetch_len       out_rem_q, out_rem_d;
    // Beats requested but not yet returned. The same quantity is the FIFO
    // reservation, so one counter serves both roles.
    logic [CW-1:0]  inflight_q, inflight_d;
    logic           arvalid_q, arvalid_d;
    word            araddr_q, araddr_d;
    axi_len         arlen_q, arlen_d;
    logic           up_q;

    logic [CW-1:0]  fifo_cnt;
    logic [32:0]    fifo_dout;
    logic           fifo_vld;

    logic [12:0]    room;
    logic [16:0]    blen_w, free_w;
    logic [8:0]     ar_blen;
    logic           ar_hs, r_hs, last_flag;

    // Burst length for the current address: capped by MAX_BURST, the words
    // still to fetch, and the words left before the next 4 KiB page.
    always_comb begin
        room   = (13'h1000 - 13'(addr_q[11:0])) >> 2;
        blen_w = 17'(MAX_BURST);
        if (17'(rem_q) < blen_w) blen_w = 17'(rem_q);
        if (17'(room) < blen_w)  blen_w = 17'(room);
        free_w  = 17'(FIFO_DEPTH) - 17'(fifo_cnt) - 17'(inflight_q);
        ar_blen = {1'b0, arlen_q} + 9'd1;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        out_rem_d  = out_rem_q;
        inflight_d = inflight_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        req_ready  = 1'b0;

        ar_hs     = arvalid_q && mem.arready;
        r_hs      = mem.rvalid && up_q;
        last_flag = (out_rem_q == 16'd1);

        if (r_hs) begin
            inflight_d = inflight_q - CW'(1);
            out_rem_d  = out_rem_q - 16'd1;
        end

        case (state_q)
            RD_IDLE: begin
                req_ready = up_q && (inflight_q == '0);
                if (req_ready && req_valid) begin
                    addr_d    = {req_addr[31:2], 2'b00};
                    rem_d     = req_len;
                    out_rem_d = req_len;
                    if (req_len != '0) state_d = RD_CALC;
                end
            end
            RD_CALC: begin
                if (free_w >= blen_w) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q;
                    arlen_d   = axi_len'(blen_w - 17'd1);
                    state_d   = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d  = 1'b0;
                    addr_d     = addr_q + {21'd0, ar_blen, 2'b00};
                    rem_d      = rem_q - {7'd0, ar_blen};
                    inflight_d = inflight_d + CW'(ar_blen);
                    state_d    = (rem_d == '0) ? RD_IDLE : RD_CALC;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            out_rem_q  <= '0;
            inflight_q <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            out_rem_q  <= out_rem_d;
            inflight_q <= inflight_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            up_q       <= 1'b1;
        end
    end

    // The last flag is attached as each beat enters, so a following request
    // reloading the counter cannot disturb words still queued.
    gfx_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wr_en_i    (r_hs),
        .wr_data_i  ({last_flag, mem.rdata}),
        .rd_valid_o (fifo_vld),
        .rd_ready_i (out_ready),
        .rd_data_o  (fifo_dout),
        .count_o    (fifo_cnt)
    );

    assign out_valid = fifo_vld;
    assign out_data  = fifo_dout[31:0];
    assign out_last  = fifo_vld && fifo_dout[32];

    assign mem.arvalid = arvalid_q;
    assign mem.araddr  = araddr_q;
    assign mem.arlen   = arlen_q;
    assign mem.arburst = AXI_BURST_INCR;
    assign mem.rready  = up_q;

    assign mem.awvalid = 1'b0;
    assign mem.awaddr  = '0;
    assign mem.awlen   = '0;
    assign mem.awburst = AXI_BURST_INCR;
    assign mem.wvalid  = 1'b0;
    assign mem.wdata   = '0;
    assign mem.wlast   = 1'b0;
    assign mem.bready  = 1'b1;

    // rlast is not needed: beats are counted internally.
    logic unused_ok;
    assign unused_ok = ^{mem.rlast, mem.awready, mem.wready, mem.bvalid, req_addr[1:0]};

endmodule

// File: tb/tb_gfx_burst_reader.sv
module tb_gfx_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [15:0] req_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    gfx_axib bus ();

    gfx_burst_reader #(.MAX_BURST(16), .FIFO_DEPTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem       (bus),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Observed traffic
    logic [31:0] ara_q[$];
    logic [7:0]  arl_q[$];
    logic [31:0] wd_q[$];
    bit          wl_q[$];
    // Expected stream
    logic [31:0] exp_d[$];
    bit          exp_l[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.arvalid && bus.arready) begin
                ara_q.push_back(bus.araddr);
                arl_q.push_back(bus.arlen);
            end
            if (out_valid && out_ready) begin
                wd_q.push_back(out_data);
                wl_q.push_back(out_last);
            end
        end
    end

    // Slave memory model: each beat returns its own byte address as data.
    logic [31:0] s_addr[$];
    int          s_cnt[$];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                s_addr.delete();
                s_cnt.delete();
            end else begin
                if (bus.rvalid && bus.rready) begin
                    s_addr[0] = s_addr[0] + 32'd4;
                    s_cnt[0]  = s_cnt[0] - 1;
                    if (s_cnt[0] == 0) begin
                        void'(s_addr.pop_front());
                        void'(s_cnt.pop_front());
                    end
                end
                if (bus.arvalid && bus.arready) begin
                    s_addr.push_back(bus.araddr);
                    s_cnt.push_back(int'(bus.arlen) + 1);
                end
            end
        end
    end

    initial begin
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.rlast  = 1'b0;
        forever begin
            @(negedge clk);
            bus.rvalid = (s_cnt.size() > 0);
            bus.rdata  = (s_cnt.size() > 0) ? s_addr[0] : 32'd0;
            bus.rlast  = (s_cnt.size() > 0) && (s_cnt[0] == 1);
        end
    end

    task automatic clear_obs();
        ara_q.delete(); arl_q.delete(); wd_q.delete(); wl_q.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic add_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(base + 32'(4 * i));
            exp_l.push_back(i == n - 1);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [15:0] l);
        int t = 0;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        while (!req_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_req_accept"}, t < 500, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n);
        int t = 0;
        while (wd_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, t < 3000, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic cmp_stream(input string tag);
        int errs = 0;
        chk({tag, "_nwords"}, wd_q.size(), exp_d.size());
        for (int i = 0; i < wd_q.size() && i < exp_d.size(); i++) begin
            if (wd_q[i] !== exp_d[i] || wl_q[i] !== exp_l[i]) begin
                if (errs == 0)
                    $display("FAIL %s_word%0d: got 0x%0h/%0b expected 0x%0h/%0b",
                             tag, i, wd_q[i], wl_q[i], exp_d[i], exp_l[i]);
                errs++;
            end
        end
        chk({tag, "_word_errs"}, errs, 0);
    endtask

    task automatic chk_ar(input string tag, input int i, input logic [31:0] a, input logic [7:0] l);
        if (i < ara_q.size()) begin
            chk($sformatf("%s_araddr%0d", tag, i), ara_q[i], a);
            chk($sformatf("%s_arlen%0d", tag, i), arl_q[i], l);
        end else begin
            chk($sformatf("%s_ar%0d_present", tag, i), 1'b0, 1'b1);
        end
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_arvalid"},   bus.arvalid, 1'b0);
        chk({tag, "_araddr"},    bus.araddr, 32'h0);
        chk({tag, "_arlen"},     bus.arlen, 8'h0);
        chk({tag, "_arburst"},   bus.arburst, 2'b01);
        chk({tag, "_rready"},    bus.rready, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"},  out_last, 1'b0);
        chk({tag, "_out_data"},  out_data, 32'h0);
    endtask

    initial begin
        int hold_err;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        out_ready   = 1'b1;
        bus.arready = 1'b1;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;

        // Reset state and write-channel tie-offs
        repeat (3) @(negedge clk);
        rst_vals("rst");
        chk("rst_awvalid", bus.awvalid, 1'b0);
        chk("rst_wvalid",  bus.wvalid, 1'b0);
        chk("rst_bready",  bus.bready, 1'b1);
        rst_n = 1'b1;
        chk("rst_rel_req_ready_low", req_ready, 1'b0);
        @(negedge clk);
        chk("rst_rel_req_ready_high", req_ready, 1'b1);
        chk("rst_rel_rready", bus.rready, 1'b1);

        // T1: 0x1000, 40 words -> 16/16/8 bursts, AR two cycles after accept
        clear_obs();
        do_req("t1", 32'h1000, 16'd40);
        chk("t1_calc_no_arvalid", bus.arvalid, 1'b0);
        @(negedge clk);
        chk("t1_arvalid_n2", bus.arvalid, 1'b1);
        wait_words("t1", 40);
        chk("t1_nar", ara_q.size(), 3);
        chk_ar("t1", 0, 32'h1000, 8'd15);
        chk_ar("t1", 1, 32'h1040, 8'd15);
        chk_ar("t1", 2, 32'h1080, 8'd7);
        add_exp(32'h1000, 40);
        cmp_stream("t1");

        // T2: 4 KiB crossing
        clear_obs();
        do_req("t2", 32'h0FF8, 16'd8);
        wait_words("t2", 8);
        chk("t2_nar", ara_q.size(), 2);
        chk_ar("t2", 0, 32'h0FF8, 8'd1);
        chk_ar("t2", 1, 32'h1000, 8'd5);
        add_exp(32'h0FF8, 8);
        cmp_stream("t2");

        // T3: consumer stalled -> credit limits to 32 beats
        clear_obs();
        out_ready = 1'b0;
        do_req("t3", 32'h2000, 16'd64);
        repeat (100) @(negedge clk);
        chk("t3_nar_stalled", ara_q.size(), 2);
        chk("t3_arvalid_low", bus.arvalid, 1'b0);
        chk("t3_out_valid_held", out_valid, 1'b1);
        chk("t3_out_data_held", out_data, 32'h2000);
        out_ready = 1'b1;
        wait_words("t3", 64);
        chk("t3_nar", ara_q.size(), 4);
        chk_ar("t3", 2, 32'h2080, 8'd15);
        add_exp(32'h2000, 64);
        cmp_stream("t3");

        // T4: arready low for 5 cycles, AR held stable
        clear_obs();
        bus.arready = 1'b0;
        do_req("t4", 32'h3000, 16'd4);
        @(negedge clk);
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h3000 || bus.arlen !== 8'd3)
                hold_err++;
            @(negedge clk);
        end
        chk("t4_ar_hold_errs", hold_err, 0);
        bus.arready = 1'b1;
        wait_words("t4", 4);
        chk("t4_nar", ara_q.size(), 1);
        add_exp(32'h3000, 4);
        cmp_stream("t4");

        // T5: back-to-back requests, last on words 3 and 5
        clear_obs();
        do_req("t5a", 32'h0000, 16'd3);
        do_req("t5b", 32'h0100, 16'd2);
        wait_words("t5", 5);
        chk_ar("t5", 0, 32'h0000, 8'd2);
        chk_ar("t5", 1, 32'h0100, 8'd1);
        add_exp(32'h0000, 3);
        add_exp(32'h0100, 2);
        cmp_stream("t5");

        // T6: zero length
        clear_obs();
        do_req("t6", 32'h4000, 16'd0);
        chk("t6_req_ready_next", req_ready, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_nar", ara_q.size(), 0);
        chk("t6_nwords", wd_q.size(), 0);

        // T7: reset in the middle of a long fetch
        clear_obs();
        do_req("t7", 32'h5000, 16'd64);
        repeat (6) @(negedge clk);
        chk("t7_busy_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_vals("t7");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_req_ready_after", req_ready, 1'b1);
        clear_obs();
        do_req("t7b", 32'h6000, 16'd2);
        wait_words("t7b", 2);
        chk("t7b_nar", ara_q.size(), 1);
        add_exp(32'h6000, 2);
        cmp_stream("t7b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
